sc_lanescheduler: RTL and testbench
===================================

# sc_lanescheduler

Paces and sequences the obstacle lanes of the Frogger playfield. A prescaled base tick drives one period counter per lane, and each lane's period shortens with the current level. When a counter expires it raises a shift request, and a round-robin arbiter grants at most one one-cycle SHIFT pulse per clock to a lane that reports READY. The block sits between the principal game state machine (level index, clear and freeze decodes) and the lane shift registers.

## Interface
- PRESCALE, 50000: clocks per base tick (1 ms at 50 MHz). Must be ≥ 2.
- LANES, 8: number of obstacle lanes. Fixed at 8 by the package.
- SC_LANESCHEDULER_CLOCK_50  in  1  system clock; single clock domain.
- SC_LANESCHEDULER_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_LANESCHEDULER_LEVEL  in  2  level index, 0..3.
- SC_LANESCHEDULER_CLEAR  in  1  synchronous restart pulse (level cleared or life lost).
- SC_LANESCHEDULER_FREEZE  in  1  hold all pacing (lose/win states).
- SC_LANESCHEDULER_READY  in  8  per-lane "can accept a shift this cycle".
- SC_LANESCHEDULER_SHIFT  out  8  one-hot or zero; one-cycle shift command.
- SC_LANESCHEDULER_PENDING  out  8  outstanding shift requests.
- SC_LANESCHEDULER_OVERRUN  out  8  sticky flag: a lane expired while its request was still pending.
- SC_LANESCHEDULER_TICK  out  1  registered base-tick strobe.

## Operation
- **Prescaler**
  - Counts 0..PRESCALE-1, then wraps.
  - Internal strobe `t` = (prescaler == PRESCALE-1).
- **Lane period**
  - base[i] = 16 + 4·i ticks, so lanes 0..7 give 16..44.
  - period[i] = base[i] >> LEVEL, so lane 0 runs at 16, 8, 4 or 2 ticks across levels 0..3.
  - Computed with 6-bit unsigned arithmetic.
- **Lane counter (6-bit per lane), on each `t`**
  - If cnt ≥ period-1: cnt ← 0 and the lane expires.
  - Otherwise: cnt ← cnt+1.
  - The ≥ compare means a LEVEL increase that shrinks the period below the current count expires the lane on the next tick. It never wraps past 63.
- **Pending**
  - Set on expiry.
  - Cleared on grant.
  - If expiry and grant hit the same lane in the same cycle, pending stays 1 and OVERRUN is not set.
  - If expiry hits an already-pending lane that is not granted that cycle, OVERRUN[i] ← 1 and only one request remains outstanding.
- **Arbiter**
  - Candidates = PENDING & READY.
  - Picks the first candidate at or after pointer `ptr` (3-bit), wrapping around.
  - On grant to lane g: SHIFT[g] is asserted next cycle and ptr ← g+1 mod 8.
  - With no candidate, ptr holds and SHIFT = 0.
- **FREEZE = 1**
  - Prescaler, counters and ptr hold.
  - No expiries and no grants; SHIFT = 0 from the next cycle.
  - PENDING and OVERRUN are retained.
- **CLEAR = 1**
  - Highest synchronous priority; overrides FREEZE.
  - Next state: prescaler, counters, PENDING, OVERRUN and ptr all 0.
  - SHIFT and TICK are 0 in the following cycle, and any grant computed in the CLEAR cycle is discarded.
- **Reset (asynchronous, active-low)**
  - All registers and outputs go to 0 immediately, including mid-operation.
  - On release, counting starts at prescaler = 0.

## Timing
- All outputs are registered.
- `t` in cycle n gives:
  - TICK = 1 in cycle n+1.
  - PENDING[i] = 1 in cycle n+1 for an expiring lane.
  - Earliest SHIFT[i] = 1 in cycle n+2 (grant decided in n+1 from PENDING & READY).
- READY is sampled in the decision cycle only. SHIFT is not held or retried; an ungranted request simply stays pending.
- Throughput: at most one SHIFT per cycle. Worst-case service delay for a READY lane is 8 cycles after PENDING rises.
- SHIFT is never asserted to a lane whose READY was 0 in the decision cycle.

## Structure
- **Shared package `sc_frogger_pkg`:**
  - NUM_LANES = 8
  - LEVEL_W = 2
  - CNT_W = 6
  - a lane_base(i) constant function (16 + 4·i)
  - LANE_MASK_T, an 8-bit vector type shared with the lane shift registers
- **Sub-module `sc_rrarbiter`:** combinational round-robin picker.
  - Inputs: 8-bit request, 3-bit ptr.
  - Outputs: one-hot grant and a valid flag.
  - Instantiated once.
- Top level holds the prescaler, counters, pending/overrun logic and output registers.

## Test plan
All scenarios use PRESCALE = 4, so `t` falls in cycles 3, 7, 11, … after reset release.
1. **Reset release:** LEVEL = 0, READY = FF → every output stays 0 until cycle 63. PENDING[0] = 1 in cycle 64; SHIFT = 01 in cycle 65 only.
2. **Fast level:** LEVEL = 3, READY = FF → SHIFT[0] pulses every 8 cycles. SHIFT[7] (period 5) pulses every 20 cycles. SHIFT is never multi-hot.
3. **Contention:** READY = 00 until PENDING = FF, then READY = FF → SHIFT = 01, 02, 04, … 80 on 8 consecutive cycles. PENDING drains to 00.
4. **Overrun:** LEVEL = 3, READY[2] held 0 across two lane-2 expiries → OVERRUN = 04 (sticky). Raising READY[2] yields exactly one SHIFT = 04.
5. **Freeze then clear:** FREEZE = 1 for 100 cycles → TICK = 0, SHIFT = 0, PENDING unchanged. CLEAR pulse with FREEZE still 1 → PENDING = OVERRUN = 00 next cycle, and counters restart from 0 (scenario 1 timing measured from the CLEAR cycle).
6. **Reset mid-operation:** RESET_InLow = 0 asynchronously during a SHIFT = 10 cycle → SHIFT, PENDING, OVERRUN and TICK drop to 0 before the next clock edge.

Source files
------------

// File: rtl/sc_frogger_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sc_frogger_pkg                                                        |
// | Shared lane constants and types for the Frogger playfield blocks.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sc_frogger_pkg;

  localparam int NUM_LANES = 8;
  localparam int LEVEL_W   = 2;
  localparam int CNT_W     = 6;
  localparam int PTR_W     = 3;

  typedef logic [NUM_LANES-1:0] LANE_MASK_T;

  // Base lane period in ticks at level 0.
  function automatic logic [CNT_W-1:0] lane_base(input int i);
    return CNT_W'(16 + 4 * i);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_rrarbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sc_rrarbiter                                                          |
// | Combinational round-robin picker: first request at or after i_ptr.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sc_rrarbiter
  import sc_frogger_pkg::*;
(
  input  LANE_MASK_T       i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output LANE_MASK_T       o_grant,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx;

  // Index arithmetic wraps naturally in PTR_W bits.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_idx = i_ptr + PTR_W'(k);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_lanescheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sc_lanescheduler                                                      |
// | Paces obstacle lanes and issues one round-robin SHIFT per clock.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sc_lanescheduler
  import sc_frogger_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int LANES    = NUM_LANES
) (
  input  logic               SC_LANESCHEDULER_CLOCK_50,
  input  logic               SC_LANESCHEDULER_RESET_InLow,
  input  logic [LEVEL_W-1:0] SC_LANESCHEDULER_LEVEL,
  input  logic               SC_LANESCHEDULER_CLEAR,
  input  logic               SC_LANESCHEDULER_FREEZE,
  input  LANE_MASK_T         SC_LANESCHEDULER_READY,
  output LANE_MASK_T         SC_LANESCHEDULER_SHIFT,
  output LANE_MASK_T         SC_LANESCHEDULER_PENDING,
  output LANE_MASK_T         SC_LANESCHEDULER_OVERRUN,
  output logic               SC_LANESCHEDULER_TICK
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  r_presc;
  logic [PTR_W-1:0] r_ptr;
  LANE_MASK_T       r_pending;
  LANE_MASK_T       r_overrun;
  LANE_MASK_T       r_shift;
  logic             r_tick;

  logic             w_t;
  logic             w_step;
  LANE_MASK_T       w_expire;
  LANE_MASK_T       w_req;
  LANE_MASK_T       w_grant;
  logic             w_valid;
  logic [PTR_W-1:0] w_gidx;

  assign w_t    = (r_presc == PS_W'(PRESCALE - 1));
  assign w_step = w_t && !SC_LANESCHEDULER_FREEZE;
  assign w_req  = r_pending & SC_LANESCHEDULER_READY;

  // Per-lane period counters; the >= compare lets a level bump expire a lane early.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] r_cnt;

    assign w_period    = lane_base(i) >> SC_LANESCHEDULER_LEVEL;
    assign w_expire[i] = w_step && (r_cnt >= w_period - CNT_W'(1));

    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
      if (!SC_LANESCHEDULER_RESET_InLow) begin
        r_cnt <= '0;
      end else if (SC_LANESCHEDULER_CLEAR) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= w_expire[i] ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  sc_rrarbiter u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  // CLEAR beats FREEZE; a grant seen during CLEAR or FREEZE is dropped.
  always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
    if (!SC_LANESCHEDULER_RESET_InLow) begin
      r_presc   <= '0;
      r_ptr     <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_shift   <= '0;
      r_tick    <= 1'b0;
    end else if (SC_LANESCHEDULER_CLEAR) begin
      r_presc   <= '0;
      r_ptr     <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_shift   <= '0;
      r_tick    <= 1'b0;
    end else if (SC_LANESCHEDULER_FREEZE) begin
      r_shift   <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_presc   <= w_t ? '0 : r_presc + PS_W'(1);
      r_tick    <= w_t;
      r_shift   <= w_grant;
      r_pending <= (r_pending & ~w_grant) | w_expire;
      r_overrun <= r_overrun | (w_expire & r_pending & ~w_grant);
      if (w_valid) r_ptr <= w_gidx + PTR_W'(1);
    end
  end

  assign SC_LANESCHEDULER_SHIFT    = r_shift;
  assign SC_LANESCHEDULER_PENDING  = r_pending;
  assign SC_LANESCHEDULER_OVERRUN  = r_overrun;
  assign SC_LANESCHEDULER_TICK     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_sc_lanescheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sc_lanescheduler                                                   |
// | Directed scenarios plus random traffic against a behavioural model.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sc_lanescheduler;

  localparam int P = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic       frz   = 1'b0;
  logic [1:0] lvl   = 2'd0;
  logic [7:0] rdy   = 8'h00;
  logic [7:0] shift, pend, ovr;
  logic       tick;

  always #5 clk = ~clk;

  sc_lanescheduler #(.PRESCALE(P), .LANES(8)) dut (
    .SC_LANESCHEDULER_CLOCK_50    (clk),
    .SC_LANESCHEDULER_RESET_InLow (rst_n),
    .SC_LANESCHEDULER_LEVEL       (lvl),
    .SC_LANESCHEDULER_CLEAR       (clr),
    .SC_LANESCHEDULER_FREEZE      (frz),
    .SC_LANESCHEDULER_READY       (rdy),
    .SC_LANESCHEDULER_SHIFT       (shift),
    .SC_LANESCHEDULER_PENDING     (pend),
    .SC_LANESCHEDULER_OVERRUN     (ovr),
    .SC_LANESCHEDULER_TICK        (tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: tick phase, per-lane tick counts, request sets.
  int       m_pc;
  int       m_cnt [8];
  bit [7:0] m_pend, m_ovr, m_shift;
  bit       m_tick;
  int       m_ptr;
  bit [7:0] dec_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_rst();
    m_pc = 0; m_ptr = 0; m_pend = '0; m_ovr = '0; m_shift = '0; m_tick = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    int       g;
    int       per;
    bit       t;
    bit [7:0] ex;
    if (clr) begin
      m_rst();
    end else if (frz) begin
      m_shift = '0;
      m_tick  = 1'b0;
    end else begin
      t    = (m_pc == P - 1);
      m_pc = (m_pc + 1) % P;
      g    = -1;
      for (int k = 0; k < 8; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % 8] && rdy[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      end
      ex = '0;
      if (t) begin
        for (int i = 0; i < 8; i++) begin
          per = (16 + 4 * i) / (1 << lvl);
          if (m_cnt[i] >= per - 1) begin
            m_cnt[i] = 0;
            ex[i]    = 1'b1;
          end else begin
            m_cnt[i]++;
          end
        end
      end
      m_shift = '0;
      if (g >= 0) begin
        m_shift[g] = 1'b1;
        m_ptr      = (g + 1) % 8;
      end
      m_ovr  = m_ovr | (ex & m_pend & ~m_shift);
      m_pend = (m_pend & ~m_shift) | ex;
      m_tick = t;
    end
  endtask

  // One clock: advance the model at the edge, then compare just after it.
  task automatic cyc();
    @(posedge clk);
    dec_rdy = rdy;
    if (rst_n) model_step();
    #1;
    chk("SHIFT", shift, m_shift);
    chk("PENDING", pend, m_pend);
    chk("OVERRUN", ovr, m_ovr);
    chk("TICK", tick, m_tick);
    chk("ONEHOT", ($countones(shift) <= 1), 1);
    chk("SHIFT_NOT_READY", shift & ~dec_rdy, 0);
  endtask

  // From cycle 0 (prescaler just zeroed) at LEVEL 0, READY all ones.
  task automatic s1_timing(input string tag);
    repeat (63) cyc();
    chk({tag, "_PEND_C63"}, pend, 8'h00);
    chk({tag, "_SHIFT_C63"}, shift, 8'h00);
    cyc();
    chk({tag, "_PEND_C64"}, pend, 8'h01);
    chk({tag, "_SHIFT_C64"}, shift, 8'h00);
    cyc();
    chk({tag, "_SHIFT_C65"}, shift, 8'h01);
    cyc();
    chk({tag, "_SHIFT_C66"}, shift, 8'h00);
  endtask

  task automatic wait_pend_full(input string tag);
    int c;
    c = 0;
    while (pend !== 8'hFF && c < 300) begin
      cyc();
      c++;
    end
    chk({tag, "_PEND_FULL"}, pend, 8'hFF);
  endtask

  initial begin
    int       hits0, hits7, bad, c;
    logic [7:0] snap;
    m_rst();

    // Reset state
    rst_n = 1'b0; lvl = 2'd0; rdy = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("RST_SHIFT", shift, 8'h00);
    chk("RST_PENDING", pend, 8'h00);
    chk("RST_OVERRUN", ovr, 8'h00);
    chk("RST_TICK", tick, 1'b0);
    rst_n = 1'b1;

    // 1. Reset release timing
    s1_timing("S1");

    // 2. Fast level: pulse counts over cycles 1..200 after a CLEAR
    clr = 1'b1; cyc(); clr = 1'b0; lvl = 2'd3; rdy = 8'hFF;
    hits0 = 0; hits7 = 0;
    for (int j = 1; j <= 200; j++) begin
      cyc();
      if (shift[0]) hits0++;
      if (shift[7]) hits7++;
    end
    chk("S2_LANE0_PULSES", hits0, 24);
    chk("S2_LANE7_PULSES", hits7, 9);

    // 3. Contention: everything pending, then drain in lane order
    clr = 1'b1; cyc(); clr = 1'b0; lvl = 2'd0; rdy = 8'h00;
    wait_pend_full("S3");
    rdy = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("S3_RR_ORDER", shift, 8'h01 << k);
    end
    chk("S3_DRAINED", pend, 8'h00);

    // 4. Overrun on lane 2
    clr = 1'b1; cyc(); clr = 1'b0; lvl = 2'd3; rdy = 8'hFB;
    c = 0;
    while (ovr === 8'h00 && c < 60) begin
      cyc();
      c++;
    end
    chk("S4_OVERRUN", ovr, 8'h04);
    rdy = 8'hFF;
    hits0 = 0;
    repeat (6) begin
      cyc();
      if (shift === 8'h04) hits0++;
    end
    chk("S4_ONE_SHIFT", hits0, 1);
    chk("S4_STICKY", ovr, 8'h04);

    // 5. Freeze with requests outstanding, then CLEAR while frozen
    rdy = 8'h00;
    repeat (10) cyc();
    snap = pend;
    frz = 1'b1; rdy = 8'hFF;
    bad = 0;
    repeat (100) begin
      cyc();
      if (tick !== 1'b0 || shift !== 8'h00 || pend !== snap) bad++;
    end
    chk("S5_FROZEN_BAD_CYCLES", bad, 0);
    clr = 1'b1;
    cyc();
    chk("S5_CLR_PEND", pend, 8'h00);
    chk("S5_CLR_OVR", ovr, 8'h00);
    clr = 1'b0; frz = 1'b0; lvl = 2'd0;
    s1_timing("S5");

    // 6. Asynchronous reset during the SHIFT=10 cycle
    clr = 1'b1; cyc(); clr = 1'b0; rdy = 8'h00;
    wait_pend_full("S6");
    rdy = 8'hFF;
    c = 0;
    while (shift !== 8'h10 && c < 10) begin
      cyc();
      c++;
    end
    chk("S6_SAW_SHIFT10", shift, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("S6_ASYNC_SHIFT", shift, 8'h00);
    chk("S6_ASYNC_PEND", pend, 8'h00);
    chk("S6_ASYNC_OVR", ovr, 8'h00);
    chk("S6_ASYNC_TICK", tick, 1'b0);
    m_rst();
    repeat (2) cyc();
    rst_n = 1'b1;

    // Random traffic against the model
    for (int j = 0; j < 600; j++) begin
      rdy = 8'($urandom);
      frz = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 63) == 0) lvl = 2'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
